memory_port_arbiter: RTL and testbench
======================================

Name: memory_port_arbiter

Overview:
Shares one downstream memory port between the instruction-fetch requester and the memory stage's load and store requesters. It latches one request at a time, drives the single memory port, and holds each requester's done and data until that requester retires or changes its request. Data accesses (older instruction) win by default; an optional fairness guard bounds instruction-fetch starvation.

Parameters:
ADDR_WIDTH, 32, address width of all ports
DATA_WIDTH, 32, data width of all ports
BYTES_WIDTH, 3, width of byte-count fields, $clog2(DATA_WIDTH/8)+1
FAIR_LIMIT, 4, consecutive data grants allowed while ifetch is pending (only with MEM_ARB_FAIRNESS_EN)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
ifetch_addr  in  ADDR_WIDTH  instruction fetch address
ifetch_activate  in  1  ifetch request; held while waiting
ifetch_data  out  DATA_WIDTH  fetched instruction word
ifetch_done  out  1  ifetch response valid
fetch_addr  in  ADDR_WIDTH  load address from memory stage
fetch_activate  in  1  load request
fetched_data  out  DATA_WIDTH  raw load word; memory stage sign/zero-extends
fetch_done  out  1  load response valid
write_addr  in  ADDR_WIDTH  store address
write_data  in  DATA_WIDTH  store data, LSB-aligned
write_activate  in  1  store request
bytes_to_write  in  BYTES_WIDTH  store size: 1, 2 or 4
write_done  out  1  store complete
mem_addr  out  ADDR_WIDTH  memory address
mem_wdata  out  DATA_WIDTH  memory write data
mem_we  out  1  1 = write, 0 = read
mem_bytes  out  BYTES_WIDTH  bytes to access; reads always use 4
mem_req  out  1  request valid; held until mem_ack
mem_rdata  in  DATA_WIDTH  read data, valid with mem_ack
mem_ack  in  1  single-cycle completion pulse

Behaviour:
- Reset:
  - State is IDLE; mem_req, mem_we and mem_addr are 0.
  - All done outputs are 0; hold registers are invalidated.
  - The fairness counter is 0.
  - An outstanding mem_req is dropped without waiting for mem_ack. The memory is reset by the same rst.
- States:
  - IDLE: no memory transaction in flight.
  - IFETCH: instruction read in flight.
  - DREAD: load in flight.
  - DWRITE: store in flight.
- Eligibility: a requester is eligible when its activate is high and it has no matching held response (see response hold below).
- IDLE selection, priority order:
  - write first, then load, then ifetch.
  - write and load asserted together is illegal; write wins.
- On a grant, the request is latched into the mem_* registers and mem_req=1 from the next cycle. Latency from activate in IDLE to mem_req is 1 cycle.
- In a busy state, mem_* outputs hold stable until mem_ack.
- On mem_ack, the next cycle:
  - state returns to IDLE;
  - mem_rdata is captured into the granted requester's hold register;
  - that requester's hold flag is set.
- Minimum turnaround is therefore ack -> done 1 cycle; a new grant follows in the same IDLE cycle.
- Response hold:
  - done = hold_valid && activate && (current addr, and for writes data/size, equal the latched request). This is combinational.
  - done and data stay stable while the requester stalls.
  - The hold is invalidated the cycle after activate drops or any compared field differs; that mismatch makes the requester eligible again.
  - Back-to-back identical requests with activate held high complete once. This is intended: reads are idempotent through this port and a repeated store writes identical data.
- Requests arriving in a busy state wait; the arbiter does not preempt.
- An activate that drops mid-transaction still completes on memory; the result is discarded.

Optional Feature:
MEM_ARB_FAIRNESS_EN
- With the macro:
  - A counter increments on each data grant made while ifetch is eligible.
  - When the counter reaches FAIR_LIMIT, the next IDLE selection grants ifetch if eligible, overriding data priority.
  - The counter clears on any ifetch grant.
- Without the macro: strict data-first priority, and no counter logic is present.

Test Plan:
- Single ifetch: ifetch_addr=0x100, activate; mem_ack with mem_rdata=0x00500093 2 cycles after mem_req -> mem_req 1 cycle after activate, mem_we=0, mem_bytes=4, ifetch_done=1 with data 0x00500093 the cycle after ack, held while activate stays high.
- Store: write_addr=0x2000, write_data=0xAB, bytes_to_write=1 -> mem_we=1, mem_bytes=1, mem_wdata=0xAB; write_done rises the cycle after ack and falls the cycle after write_activate drops.
- Contention: ifetch and load 0x3000 asserted the same cycle -> load granted first; ifetch granted in the IDLE cycle after the load ack; fetched_data and ifetch_data both correct.
- Reissue: load 0x3000 completes, then fetch_addr changes to 0x3004 with activate held -> fetch_done drops the next cycle and a new mem_req for 0x3004 is issued.
- Reset mid-transaction: rst in DWRITE before ack -> mem_req=0 and all done=0 the next cycle; a late mem_ack is ignored.
- With MEM_ARB_FAIRNESS_EN, FAIR_LIMIT=4: continuous distinct loads plus ifetch pending -> ifetch granted after exactly 4 load grants. Without the macro, ifetch is never granted while loads are continuously pending.

Source files
------------

// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter: shares one memory port between instruction fetch,
// loads and stores. One request is latched at a time. Each requester's
// response is held until it drops or changes its request.
// Optional macro MEM_ARB_FAIRNESS_EN: after FAIR_LIMIT data grants made while
// ifetch is waiting, the next selection goes to ifetch.
//
// state    | meaning
// ---------+-------------------------------
// S_IDLE   | no memory transaction in flight
// S_IFETCH | instruction read in flight
// S_DREAD  | load in flight
// S_DWRITE | store in flight
module memory_port_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int BYTES_WIDTH = 3,
    parameter int FAIR_LIMIT  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDR_WIDTH-1:0]  ifetch_addr,
    input  logic                   ifetch_activate,
    output logic [DATA_WIDTH-1:0]  ifetch_data,
    output logic                   ifetch_done,
    input  logic [ADDR_WIDTH-1:0]  fetch_addr,
    input  logic                   fetch_activate,
    output logic [DATA_WIDTH-1:0]  fetched_data,
    output logic                   fetch_done,
    input  logic [ADDR_WIDTH-1:0]  write_addr,
    input  logic [DATA_WIDTH-1:0]  write_data,
    input  logic                   write_activate,
    input  logic [BYTES_WIDTH-1:0] bytes_to_write,
    output logic                   write_done,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0]  mem_wdata,
    output logic                   mem_we,
    output logic [BYTES_WIDTH-1:0] mem_bytes,
    output logic                   mem_req,
    input  logic [DATA_WIDTH-1:0]  mem_rdata,
    input  logic                   mem_ack
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_IFETCH = 2'd1;
    localparam logic [1:0] S_DREAD  = 2'd2;
    localparam logic [1:0] S_DWRITE = 2'd3;

    localparam logic [BYTES_WIDTH-1:0] WORD_BYTES = BYTES_WIDTH'(DATA_WIDTH / 8);

    if (FAIR_LIMIT < 1) begin : g_fair_limit_check
        $error("FAIR_LIMIT must be at least 1");
    end

    logic [1:0]             state_q, state_d;
    logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
    logic                   mem_we_q, mem_we_d;
    logic [BYTES_WIDTH-1:0] mem_bytes_q, mem_bytes_d;
    logic                   mem_req_q, mem_req_d;

    // response hold registers, one set per requester
    logic                   if_hv_q, ld_hv_q, wr_hv_q;
    logic [ADDR_WIDTH-1:0]  if_ha_q, ld_ha_q, wr_ha_q;
    logic [DATA_WIDTH-1:0]  if_hd_q, ld_hd_q, wr_hd_q;
    logic [BYTES_WIDTH-1:0] wr_hb_q;

    logic if_done, ld_done, wr_done;
    logic if_elig, ld_elig, wr_elig;
    logic grant_if, grant_ld, grant_wr;
    logic fair_force;
    logic ack_fire;

`ifdef MEM_ARB_FAIRNESS_EN
    localparam int CW = $clog2(FAIR_LIMIT + 1);
    localparam logic [CW-1:0] FAIR_MAX = CW'(FAIR_LIMIT);
    logic [CW-1:0] fair_q;
`endif

    // a held response is only presented while the requester still asks for it
    always_comb begin
        if_done = if_hv_q && ifetch_activate && (ifetch_addr == if_ha_q);
        ld_done = ld_hv_q && fetch_activate && (fetch_addr == ld_ha_q);
        wr_done = wr_hv_q && write_activate && (write_addr == wr_ha_q)
                  && (write_data == wr_hd_q) && (bytes_to_write == wr_hb_q);
        if_elig = ifetch_activate && !if_done;
        ld_elig = fetch_activate && !ld_done;
        wr_elig = write_activate && !wr_done;
        ack_fire = (state_q != S_IDLE) && mem_ack;
    end

    // IDLE selection: store, then load, then ifetch (fairness may override)
    always_comb begin
        fair_force = 1'b0;
`ifdef MEM_ARB_FAIRNESS_EN
        fair_force = if_elig && (fair_q >= FAIR_MAX);
`endif
        grant_if = 1'b0;
        grant_ld = 1'b0;
        grant_wr = 1'b0;
        if (state_q == S_IDLE) begin
            if (fair_force)   grant_if = 1'b1;
            else if (wr_elig) grant_wr = 1'b1;
            else if (ld_elig) grant_ld = 1'b1;
            else if (if_elig) grant_if = 1'b1;
        end
    end

    // next-state and memory port request latching
    always_comb begin
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = mem_we_q;
        mem_bytes_d = mem_bytes_q;
        mem_req_d   = mem_req_q;
        if (state_q == S_IDLE) begin
            if (grant_wr) begin
                state_d     = S_DWRITE;
                mem_addr_d  = write_addr;
                mem_wdata_d = write_data;
                mem_we_d    = 1'b1;
                mem_bytes_d = bytes_to_write;
                mem_req_d   = 1'b1;
            end else if (grant_ld) begin
                state_d     = S_DREAD;
                mem_addr_d  = fetch_addr;
                mem_wdata_d = '0;
                mem_we_d    = 1'b0;
                mem_bytes_d = WORD_BYTES;
                mem_req_d   = 1'b1;
            end else if (grant_if) begin
                state_d     = S_IFETCH;
                mem_addr_d  = ifetch_addr;
                mem_wdata_d = '0;
                mem_we_d    = 1'b0;
                mem_bytes_d = WORD_BYTES;
                mem_req_d   = 1'b1;
            end
        end else if (mem_ack) begin
            state_d   = S_IDLE;
            mem_req_d = 1'b0;
        end
    end

    // FSM and memory port registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_bytes_q <= '0;
            mem_req_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            mem_bytes_q <= mem_bytes_d;
            mem_req_q   <= mem_req_d;
        end
    end

    // capture completions into hold registers; drop a hold once it stops matching
    always_ff @(posedge clk) begin
        if (rst) begin
            if_hv_q <= 1'b0;
            ld_hv_q <= 1'b0;
            wr_hv_q <= 1'b0;
            if_ha_q <= '0;
            ld_ha_q <= '0;
            wr_ha_q <= '0;
            if_hd_q <= '0;
            ld_hd_q <= '0;
            wr_hd_q <= '0;
            wr_hb_q <= '0;
        end else begin
            if (ack_fire && state_q == S_IFETCH) begin
                if_hv_q <= 1'b1;
                if_ha_q <= mem_addr_q;
                if_hd_q <= mem_rdata;
            end else if (if_hv_q && !if_done) begin
                if_hv_q <= 1'b0;
            end
            if (ack_fire && state_q == S_DREAD) begin
                ld_hv_q <= 1'b1;
                ld_ha_q <= mem_addr_q;
                ld_hd_q <= mem_rdata;
            end else if (ld_hv_q && !ld_done) begin
                ld_hv_q <= 1'b0;
            end
            // the store hold keeps the request it completed, not read data
            if (ack_fire && state_q == S_DWRITE) begin
                wr_hv_q <= 1'b1;
                wr_ha_q <= mem_addr_q;
                wr_hd_q <= mem_wdata_q;
                wr_hb_q <= mem_bytes_q;
            end else if (wr_hv_q && !wr_done) begin
                wr_hv_q <= 1'b0;
            end
        end
    end

`ifdef MEM_ARB_FAIRNESS_EN
    // count data grants that made a waiting ifetch lose
    always_ff @(posedge clk) begin
        if (rst) begin
            fair_q <= '0;
        end else if (grant_if) begin
            fair_q <= '0;
        end else if ((grant_wr || grant_ld) && if_elig && (fair_q < FAIR_MAX)) begin
            fair_q <= fair_q + 1'b1;
        end
    end
`endif

    // outputs
    always_comb begin
        mem_addr     = mem_addr_q;
        mem_wdata    = mem_wdata_q;
        mem_we       = mem_we_q;
        mem_bytes    = mem_bytes_q;
        mem_req      = mem_req_q;
        ifetch_done  = if_done;
        fetch_done   = ld_done;
        write_done   = wr_done;
        ifetch_data  = if_hd_q;
        fetched_data = ld_hd_q;
    end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Self-checking bench for memory_port_arbiter: directed scenarios plus a
// randomized contention run checked against a priority-order model.
module tb_memory_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] ifetch_addr, fetch_addr, write_addr, mem_addr;
    logic          ifetch_activate, fetch_activate, write_activate;
    logic [DW-1:0] ifetch_data, fetched_data, write_data, mem_wdata, mem_rdata;
    logic          ifetch_done, fetch_done, write_done;
    logic [BW-1:0] bytes_to_write, mem_bytes;
    logic          mem_we, mem_req, mem_ack;

    int n_checks = 0;
    int n_pass   = 0;

    memory_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BYTES_WIDTH(BW), .FAIR_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .ifetch_addr(ifetch_addr), .ifetch_activate(ifetch_activate),
        .ifetch_data(ifetch_data), .ifetch_done(ifetch_done),
        .fetch_addr(fetch_addr), .fetch_activate(fetch_activate),
        .fetched_data(fetched_data), .fetch_done(fetch_done),
        .write_addr(write_addr), .write_data(write_data),
        .write_activate(write_activate), .bytes_to_write(bytes_to_write),
        .write_done(write_done),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_bytes(mem_bytes), .mem_req(mem_req),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // wait (bounded) at negedges until mem_req is high
    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (mem_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        ifetch_activate = 0; fetch_activate = 0; write_activate = 0;
        ifetch_addr = 0; fetch_addr = 0; write_addr = 0; write_data = 0;
        bytes_to_write = 0; mem_ack = 0; mem_rdata = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (mem_req !== 1'b0) $display("FAIL reset_req: got %0b want 0", mem_req); else n_pass++;
        n_checks++; if (mem_we !== 1'b0) $display("FAIL reset_we: got %0b want 0", mem_we); else n_pass++;
        n_checks++; if (mem_addr !== 32'h0) $display("FAIL reset_addr: got %h want 0", mem_addr); else n_pass++;
        n_checks++; if ({ifetch_done, fetch_done, write_done} !== 3'b000)
            $display("FAIL reset_done: got %b want 000", {ifetch_done, fetch_done, write_done}); else n_pass++;
    endtask

    task automatic test_single_ifetch;
        ifetch_addr = 32'h100; ifetch_activate = 1;
        @(negedge clk);
        n_checks++; if (mem_req !== 1'b1) $display("FAIL ifetch_latency: mem_req got %0b want 1", mem_req); else n_pass++;
        n_checks++; if (mem_addr !== 32'h100 || mem_we !== 1'b0 || mem_bytes !== 3'd4)
            $display("FAIL ifetch_fields: addr %h we %0b bytes %0d want 100 0 4", mem_addr, mem_we, mem_bytes); else n_pass++;
        @(negedge clk);
        n_checks++; if (mem_req !== 1'b1 || ifetch_done !== 1'b0)
            $display("FAIL ifetch_wait: req %0b done %0b want 1 0", mem_req, ifetch_done); else n_pass++;
        mem_ack = 1; mem_rdata = 32'h00500093;
        @(negedge clk);
        mem_ack = 0; mem_rdata = 32'hDEADBEEF;
        n_checks++; if (ifetch_done !== 1'b1 || ifetch_data !== 32'h00500093)
            $display("FAIL ifetch_done: done %0b data %h want 1 00500093", ifetch_done, ifetch_data); else n_pass++;
        repeat (2) @(negedge clk);
        n_checks++; if (ifetch_done !== 1'b1 || ifetch_data !== 32'h00500093 || mem_req !== 1'b0)
            $display("FAIL ifetch_hold: done %0b data %h req %0b want 1 00500093 0", ifetch_done, ifetch_data, mem_req); else n_pass++;
        ifetch_activate = 0;
        @(negedge clk);
        n_checks++; if (ifetch_done !== 1'b0 || mem_req !== 1'b0)
            $display("FAIL ifetch_release: done %0b req %0b want 0 0", ifetch_done, mem_req); else n_pass++;
    endtask

    task automatic test_store;
        write_addr = 32'h2000; write_data = 32'hAB; bytes_to_write = 3'd1; write_activate = 1;
        @(negedge clk);
        n_checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_bytes !== 3'd1 || mem_wdata !== 32'hAB || mem_addr !== 32'h2000)
            $display("FAIL store_fields: req %0b we %0b bytes %0d wdata %h addr %h want 1 1 1 ab 2000",
                     mem_req, mem_we, mem_bytes, mem_wdata, mem_addr); else n_pass++;
        mem_ack = 1;
        @(negedge clk);
        mem_ack = 0;
        n_checks++; if (write_done !== 1'b1) $display("FAIL store_done: got %0b want 1", write_done); else n_pass++;
        @(negedge clk);
        write_activate = 0;
        @(negedge clk);
        n_checks++; if (write_done !== 1'b0 || mem_req !== 1'b0)
            $display("FAIL store_release: done %0b req %0b want 0 0", write_done, mem_req); else n_pass++;
    endtask

    task automatic test_contention;
        ifetch_addr = 32'h400; ifetch_activate = 1;
        fetch_addr = 32'h3000; fetch_activate = 1;
        @(negedge clk);
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h3000)
            $display("FAIL contention_first: req %0b addr %h want 1 3000", mem_req, mem_addr); else n_pass++;
        mem_ack = 1; mem_rdata = 32'h11112222;
        @(negedge clk);
        mem_ack = 0;
        n_checks++; if (fetch_done !== 1'b1 || fetched_data !== 32'h11112222 || mem_req !== 1'b0)
            $display("FAIL contention_load: done %0b data %h req %0b want 1 11112222 0", fetch_done, fetched_data, mem_req); else n_pass++;
        @(negedge clk);
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h400)
            $display("FAIL contention_second: req %0b addr %h want 1 400", mem_req, mem_addr); else n_pass++;
        mem_ack = 1; mem_rdata = 32'h33334444;
        @(negedge clk);
        mem_ack = 0;
        n_checks++; if (ifetch_done !== 1'b1 || ifetch_data !== 32'h33334444 || fetch_done !== 1'b1 || fetched_data !== 32'h11112222)
            $display("FAIL contention_data: if %0b/%h ld %0b/%h want 1/33334444 1/11112222",
                     ifetch_done, ifetch_data, fetch_done, fetched_data); else n_pass++;
        ifetch_activate = 0; fetch_activate = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reissue;
        bit ok;
        fetch_addr = 32'h3000; fetch_activate = 1;
        wait_req(ok);
        mem_ack = 1; mem_rdata = 32'hA5A5A5A5;
        @(negedge clk);
        mem_ack = 0;
        n_checks++; if (!ok || fetch_done !== 1'b1 || fetched_data !== 32'hA5A5A5A5)
            $display("FAIL reissue_first: ok %0b done %0b data %h want 1 1 a5a5a5a5", ok, fetch_done, fetched_data); else n_pass++;
        @(negedge clk);
        fetch_addr = 32'h3004;
        @(negedge clk);
        n_checks++; if (fetch_done !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h3004)
            $display("FAIL reissue_new: done %0b req %0b addr %h want 0 1 3004", fetch_done, mem_req, mem_addr); else n_pass++;
        mem_ack = 1; mem_rdata = 32'h5A5A0001;
        @(negedge clk);
        mem_ack = 0;
        n_checks++; if (fetch_done !== 1'b1 || fetched_data !== 32'h5A5A0001)
            $display("FAIL reissue_second: done %0b data %h want 1 5a5a0001", fetch_done, fetched_data); else n_pass++;
        fetch_activate = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        bit ok;
        write_addr = 32'h2100; write_data = 32'h1234; bytes_to_write = 3'd2; write_activate = 1;
        wait_req(ok);
        n_checks++; if (!ok || mem_we !== 1'b1) $display("FAIL rstmid_req: ok %0b we %0b want 1 1", ok, mem_we); else n_pass++;
        rst = 1; write_activate = 0;
        @(negedge clk);
        rst = 0;
        n_checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || {ifetch_done, fetch_done, write_done} !== 3'b000)
            $display("FAIL rstmid_clear: req %0b we %0b done %b want 0 0 000", mem_req, mem_we,
                     {ifetch_done, fetch_done, write_done}); else n_pass++;
        mem_ack = 1; mem_rdata = 32'hFFFF0000;
        @(negedge clk);
        mem_ack = 0;
        write_activate = 1;
        n_checks++; if (write_done !== 1'b0 || mem_req !== 1'b0)
            $display("FAIL rstmid_lateack: done %0b req %0b want 0 0", write_done, mem_req); else n_pass++;
        @(negedge clk);
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h2100 || mem_bytes !== 3'd2)
            $display("FAIL rstmid_regrant: req %0b addr %h bytes %0d want 1 2100 2", mem_req, mem_addr, mem_bytes); else n_pass++;
        mem_ack = 1;
        @(negedge clk);
        mem_ack = 0;
        n_checks++; if (write_done !== 1'b1) $display("FAIL rstmid_done: got %0b want 1", write_done); else n_pass++;
        write_activate = 0;
        repeat (2) @(negedge clk);
    endtask

    // continuous distinct loads with an ifetch waiting
    task automatic test_starvation;
        bit ok;
        bit exp_if;
        bit if_served;
        int fair_cnt;
        int load_idx;
        logic [AW-1:0] exp_addr;
        fair_cnt = 0; load_idx = 0; if_served = 0;
        ifetch_addr = 32'h500; ifetch_activate = 1;
        fetch_addr = 32'h6000; fetch_activate = 1;
        for (int g = 0; g < 6; g++) begin
`ifdef MEM_ARB_FAIRNESS_EN
            exp_if = !if_served && (fair_cnt == 4);
`else
            exp_if = 1'b0;
`endif
            exp_addr = exp_if ? 32'h500 : 32'h6000 + 32'(4 * load_idx);
            wait_req(ok);
            n_checks++; if (!ok || mem_addr !== exp_addr)
                $display("FAIL starve_grant%0d: ok %0b addr %h want 1 %h", g, ok, mem_addr, exp_addr); else n_pass++;
            mem_ack = 1; mem_rdata = $urandom;
            @(negedge clk);
            mem_ack = 0;
            if (exp_if) begin
                fair_cnt = 0;
                if_served = 1;
            end else begin
                if (!if_served) fair_cnt++;
                load_idx++;
                if (g < 5) fetch_addr = 32'h6000 + 32'(4 * load_idx);
            end
        end
        n_checks++; if (ifetch_done !== if_served)
            $display("FAIL starve_ifetch_done: got %0b want %0b", ifetch_done, if_served); else n_pass++;
        ifetch_activate = 0; fetch_activate = 0;
        repeat (2) @(negedge clk);
    endtask

    // random mixes of simultaneous requests from IDLE; model = priority order
    task automatic test_random;
        bit ok;
        bit use_w, use_l, use_i;
        int order[$];
        int who;
        int dly;
        logic [DW-1:0] exp_if_data, exp_ld_data;
        logic [AW-1:0] exp_addr;
        logic [BW-1:0] exp_bytes;
        logic          exp_we;
        int sz;
        for (int it = 0; it < 40; it++) begin
            use_w = 1'($urandom);
            use_l = use_w ? 1'b0 : 1'($urandom);
            use_i = 1'($urandom);
            if (!use_w && !use_l && !use_i) use_i = 1'b1;
            ifetch_addr = {$urandom_range(0, 1023), 2'b00};
            fetch_addr  = {$urandom_range(0, 1023), 2'b00} + 32'h10000;
            write_addr  = {$urandom_range(0, 1023), 2'b00} + 32'h20000;
            write_data  = $urandom;
            sz = $urandom_range(0, 2);
            bytes_to_write = (sz == 0) ? 3'd1 : (sz == 1) ? 3'd2 : 3'd4;
            ifetch_activate = use_i; fetch_activate = use_l; write_activate = use_w;
            order.delete();
            if (use_w) order.push_back(2);
            if (use_l) order.push_back(1);
            if (use_i) order.push_back(0);
            exp_if_data = 0; exp_ld_data = 0;
            while (order.size() > 0) begin
                who = order.pop_front();
                exp_addr  = (who == 2) ? write_addr : (who == 1) ? fetch_addr : ifetch_addr;
                exp_we    = (who == 2);
                exp_bytes = (who == 2) ? bytes_to_write : 3'd4;
                wait_req(ok);
                n_checks++; if (!ok || mem_addr !== exp_addr || mem_we !== exp_we || mem_bytes !== exp_bytes
                               || (exp_we && mem_wdata !== write_data))
                    $display("FAIL rand_req it%0d who%0d: ok %0b addr %h we %0b bytes %0d wdata %h want %h %0b %0d %h",
                             it, who, ok, mem_addr, mem_we, mem_bytes, mem_wdata, exp_addr, exp_we, exp_bytes, write_data);
                else n_pass++;
                dly = $urandom_range(0, 3);
                repeat (dly) @(negedge clk);
                mem_ack = 1; mem_rdata = $urandom;
                if (who == 0) exp_if_data = mem_rdata;
                if (who == 1) exp_ld_data = mem_rdata;
                @(negedge clk);
                mem_ack = 0;
            end
            n_checks++; if (ifetch_done !== use_i || fetch_done !== use_l || write_done !== use_w
                           || (use_i && ifetch_data !== exp_if_data) || (use_l && fetched_data !== exp_ld_data))
                $display("FAIL rand_done it%0d: done if/ld/wr %0b%0b%0b data %h %h want %0b%0b%0b %h %h", it,
                         ifetch_done, fetch_done, write_done, ifetch_data, fetched_data,
                         use_i, use_l, use_w, exp_if_data, exp_ld_data);
            else n_pass++;
            ifetch_activate = 0; fetch_activate = 0; write_activate = 0;
            repeat (2) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_single_ifetch();
        test_store();
        test_contention();
        test_reissue();
        test_reset_mid();
        test_starvation();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
